// File: rtl/sar_pkg.sv
// Shared SAR result types, used by the SAR logic, the result buffer and the readout.
package sar_pkg;

  localparam int SAR_W = 10;

  typedef logic [SAR_W-1:0] sar_word_t;

  localparam int DEF_DEPTH    = 4;
  localparam int DEF_AVG_LOG2 = 2;

  // Width of a 0..depth occupancy count.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// First-word-fall-through FIFO: head word is visible the cycle after it is pushed.
// A push while full is accepted only together with a pop; otherwise the caller sees it dropped.
module sar_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head reads as zero while empty so reset and flushed states present a clean bus.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sar_result_buffer.sv
// SAR result capture (+ optional 2^AVG_LOG2 averaging under SAR_RESULT_AVG_EN) into a FWFT queue; eoc-to-out_valid 2 cycles.
// Backpressure via out_valid/out_ready; a word arriving at a full queue with no pop is dropped and sets sticky overflow.
module sar_result_buffer
  import sar_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SAR_W-1:0]       sar,
  input  logic                   eoc,
  input  logic                   flush,
  output logic [SAR_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sar_result_buffer: DEPTH must be a power of two >= 2");
  end
  if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg_log2
    $error("sar_result_buffer: AVG_LOG2 must be in 1..4");
  end

  logic      eoc_q;
  logic      cap_vld;
  sar_word_t cap_data;
  logic      push_vld;
  sar_word_t push_word;
  logic      pop;
  logic      full;
  logic      empty;
  logic      drop;

  // Rising-edge capture: a long eoc pulse yields a single sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eoc_q    <= 1'b0;
      cap_vld  <= 1'b0;
      cap_data <= '0;
    end else begin
      eoc_q   <= eoc;
      cap_vld <= eoc & ~eoc_q & ~flush;
      if (eoc && !eoc_q) begin
        cap_data <= sar;
      end
    end
  end

`ifdef SAR_RESULT_AVG_EN
  localparam int ACC_W = SAR_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    acc_rnd;
  logic [AVG_LOG2-1:0] scnt;
  logic                last_sample;

  // The completing sample is summed and pushed in the same cycle to keep the 2-cycle latency.
  assign acc_sum     = acc + ACC_W'(cap_data);
  assign acc_rnd     = acc_sum + ACC_W'(1 << (AVG_LOG2 - 1));
  assign last_sample = (scnt == {AVG_LOG2{1'b1}});
  assign push_vld    = cap_vld & last_sample & ~flush;
  assign push_word   = acc_rnd[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      scnt <= '0;
    end else if (flush) begin
      acc  <= '0;
      scnt <= '0;
    end else if (cap_vld) begin
      scnt <= scnt + AVG_LOG2'(1);
      acc  <= last_sample ? '0 : acc_sum;
    end
  end
`else
  assign push_vld  = cap_vld & ~flush;
  assign push_word = cap_data;
`endif

  assign pop  = out_valid & out_ready;
  assign drop = push_vld & full & ~pop;

  sar_sync_fifo #(
    .WIDTH (SAR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_vld),
    .push_data (push_word),
    .pop       (pop),
    .flush     (flush),
    .head_data (out_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = ~empty;

  // A drop in the same cycle as clr_ovf must stay visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_result_buffer.sv
// Directed bench for sar_result_buffer (DEPTH=4, AVG_LOG2=2); averaging vectors run when SAR_RESULT_AVG_EN is defined.
module tb_sar_result_buffer;
  import sar_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [SAR_W-1:0] sar;
  logic            eoc;
  logic            flush;
  logic [SAR_W-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      fifo_count;
  logic            overflow;
  logic            clr_ovf;

  int total = 0;
  int bad   = 0;

  sar_result_buffer #(
    .DEPTH    (4),
    .AVG_LOG2 (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sar        (sar),
    .eoc        (eoc),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One eoc pulse; returns after the edge at which its word (if any) is pushed.
  task automatic capture(input logic [SAR_W-1:0] v);
    sar = v;
    eoc = 1'b1;
    step(1);
    eoc = 1'b0;
    step(1);
  endtask

  initial begin
    logic [SAR_W-1:0] drain_exp [4];
    int peak;

    rst = 1'b1; eoc = 1'b0; sar = '0; flush = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    step(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    step(1);
    chk("idle_valid", out_valid, 0);

`ifndef SAR_RESULT_AVG_EN
    // Single pulse, consumer ready: valid exactly in cycle 2, for one cycle.
    sar = 10'h2A5; eoc = 1'b1; out_ready = 1'b1;
    step(1);
    chk("lat_c1_valid", out_valid, 0);
    eoc = 1'b0;
    step(1);
    chk("lat_c2_valid", out_valid, 1);
    chk("lat_c2_data", out_data, 10'h2A5);
    chk("lat_c2_count", fifo_count, 1);
    step(1);
    chk("pop_valid", out_valid, 0);
    chk("pop_count", fifo_count, 0);

    // eoc held high for 5 cycles gives one word.
    out_ready = 1'b0; sar = 10'h155; eoc = 1'b1; peak = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) eoc = 1'b0;
      step(1);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    chk("hold_peak", peak, 1);
    chk("hold_data", out_data, 10'h155);
    out_ready = 1'b1;
    step(1);
    chk("hold_drained", fifo_count, 0);
    out_ready = 1'b0;

    // Fill with a stalled consumer, then drop the fifth word.
    capture(10'h011); capture(10'h022); capture(10'h033); capture(10'h044);
    chk("fill_count", fifo_count, 4);
    chk("fill_ovf", overflow, 0);
    capture(10'h055);
    chk("drop_count", fifo_count, 4);
    chk("drop_ovf", overflow, 1);
    chk("drop_head", out_data, 10'h011);

    // Full with push and pop on the same edge.
    sar = 10'h066; eoc = 1'b1;
    step(1);
    eoc = 1'b0; out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("pp_count", fifo_count, 4);
    chk("pp_head", out_data, 10'h022);

    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);

    // Drop coincident with clr_ovf: set wins.
    sar = 10'h077; eoc = 1'b1;
    step(1);
    eoc = 1'b0; clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("set_wins_ovf", overflow, 1);
    chk("set_wins_count", fifo_count, 4);

    drain_exp[0] = 10'h022; drain_exp[1] = 10'h033; drain_exp[2] = 10'h044; drain_exp[3] = 10'h066;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), out_valid, 1);
      chk($sformatf("drain%0d_data", i), out_data, drain_exp[i]);
      step(1);
    end
    out_ready = 1'b0;
    chk("drain_count", fifo_count, 0);
    chk("drain_valid", out_valid, 0);

    // flush coincident with a capture: stored word and new sample both gone, overflow kept.
    capture(10'h0AB);
    chk("pre_flush_count", fifo_count, 1);
    sar = 10'h0CD; eoc = 1'b1; flush = 1'b1;
    step(1);
    flush = 1'b0; eoc = 1'b0;
    chk("flush_count", fifo_count, 0);
    step(2);
    chk("flush_late_count", fifo_count, 0);
    chk("flush_late_valid", out_valid, 0);
    chk("flush_keeps_ovf", overflow, 1);

    // flush coincident with the push cycle.
    sar = 10'h0EE; eoc = 1'b1;
    step(1);
    eoc = 1'b0; flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(1);
    chk("flush_push_count", fifo_count, 0);

    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("clr_ovf2", overflow, 0);

    capture(10'h3FF);
    chk("resume_data", out_data, 10'h3FF);
    chk("resume_count", fifo_count, 1);
`else
    // 100,101,101,102 -> (404+2)>>2 = 101, latency 2 from the final eoc.
    capture(10'd100); capture(10'd101); capture(10'd101);
    chk("avg_partial_count", fifo_count, 0);
    sar = 10'd102; eoc = 1'b1;
    step(1);
    eoc = 1'b0;
    chk("avg_c1_valid", out_valid, 0);
    step(1);
    chk("avg_c2_valid", out_valid, 1);
    chk("avg_c2_data", out_data, 10'd101);
    chk("avg_c2_count", fifo_count, 1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("avg_pop_count", fifo_count, 0);

    for (int i = 0; i < 3; i++) capture(10'd1023);
    chk("avg_max_partial", fifo_count, 0);
    capture(10'd1023);
    chk("avg_max_data", out_data, 10'd1023);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;

    // Reset mid-average: only the new four samples count -> (8+9+9+9+2)>>2 = 9.
    capture(10'd200); capture(10'd200);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    capture(10'd8); capture(10'd9); capture(10'd9);
    chk("avg_rst_partial", fifo_count, 0);
    capture(10'd9);
    chk("avg_rst_count", fifo_count, 1);
    chk("avg_rst_data", out_data, 10'd9);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;

    // flush discards partial accumulation: (4*5+2)>>2 = 5.
    capture(10'd500); capture(10'd500);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    capture(10'd5); capture(10'd5); capture(10'd5);
    chk("avg_flush_partial", fifo_count, 0);
    capture(10'd5);
    chk("avg_flush_data", out_data, 10'd5);
    chk("avg_flush_count", fifo_count, 1);
`endif

    // Asynchronous reset mid-cycle clears outputs without waiting for a clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ovf", overflow, 0);
    step(1);
    rst = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
